// File: rtl/video_seg_pkg.sv
// rtl/video_seg_pkg.sv - shared constants, state type and header layout for the segment packer
package video_seg_pkg;

  localparam logic [15:0] HDR_MAGIC    = 16'hA55A;
  localparam int          FIFO_W       = 49;
  localparam int          HDR_FLAG_BIT = 48;

  // Header field offsets; the Ethernet-side depacketizer decodes with the same values.
  localparam int HDR_MAGIC_LSB = 32;
  localparam int HDR_INDEX_LSB = 16;
  localparam int HDR_VCNT_LSB  = 5;

  typedef enum logic [1:0] {IDLE, SEND, DROP} seg_state_t;

  function automatic logic [FIFO_W-1:0] make_header(input logic [11:0] idx,
                                                    input logic [10:0] vcnt);
    logic [FIFO_W-1:0] h;
    h = '0;
    h[HDR_FLAG_BIT]            = 1'b1;
    h[HDR_MAGIC_LSB +: 16]     = HDR_MAGIC;
    h[HDR_INDEX_LSB +: 12]     = idx;
    h[HDR_VCNT_LSB +: 11]      = vcnt;
    return h;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/video_seg_packer.sv
// rtl/video_seg_packer.sv - slices active lines into segments and packs pixel pairs behind a header word
module video_seg_packer
  import video_seg_pkg::*;
#(
  parameter int SEG_PIXELS = 640,
  parameter int CNT_W      = 16
) (
  input  logic              rx0_pclk,
  input  logic              rstbtn_n,
  input  logic              video_en,
  input  logic [10:0]       video_vcnt,
  input  logic [11:0]       index,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  input  logic              fifo_full,
  input  logic              fifo_prog_full,
  output logic [FIFO_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  short_cnt,
  output logic              overflow
);

  localparam int              PC_W     = $clog2(SEG_PIXELS + 1);
  localparam logic [PC_W-1:0] SEG_LAST = PC_W'(SEG_PIXELS);

  seg_state_t        state_q, state_d;
  logic [PC_W-1:0]   pcnt_q, pcnt_d;
  logic [23:0]       held_q, held_d;
  logic [FIFO_W-1:0] din_q, din_d;
  logic              wr_q, wr_d;
  logic              ovf_q, ovf_d;
  logic              drop_inc, short_inc, start_seg;
  logic [23:0]       pixel;

  assign pixel = {red, green, blue};

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    held_d    = held_q;
    din_d     = din_q;
    wr_d      = 1'b0;
    ovf_d     = ovf_q;
    drop_inc  = 1'b0;
    short_inc = 1'b0;
    start_seg = 1'b0;

    case (state_q)
      IDLE: begin
        if (video_en) start_seg = 1'b1;
      end
      SEND: begin
        if (video_en) begin
          if (pcnt_q == SEG_LAST) begin
            start_seg = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
            // Odd pixel completes a pair; a full FIFO abandons the rest of the segment.
            if (pcnt_q[0]) begin
              if (fifo_full) begin
                ovf_d   = 1'b1;
                state_d = DROP;
              end else begin
                wr_d  = 1'b1;
                din_d = {1'b0, held_q, pixel};
              end
            end else begin
              held_d = pixel;
            end
          end
        end else begin
          state_d = IDLE;
          pcnt_d  = '0;
          if (pcnt_q != SEG_LAST) begin
            short_inc = 1'b1;
            if (pcnt_q[0]) begin
              if (fifo_full) begin
                ovf_d = 1'b1;
              end else begin
                wr_d  = 1'b1;
                din_d = {1'b0, held_q, 24'h0};
              end
            end
          end
        end
      end
      DROP: begin
        if (video_en) begin
          if (pcnt_q == SEG_LAST) start_seg = 1'b1;
          else                    pcnt_d = pcnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          pcnt_d  = '0;
          if (pcnt_q != SEG_LAST) short_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Segment start shares one decision path from IDLE and from a full segment.
    if (start_seg) begin
      pcnt_d = PC_W'(1);
      held_d = pixel;
      if (fifo_prog_full) begin
        drop_inc = 1'b1;
        state_d  = DROP;
      end else if (fifo_full) begin
        ovf_d   = 1'b1;
        state_d = DROP;
      end else begin
        wr_d    = 1'b1;
        din_d   = make_header(index, video_vcnt);
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      held_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      held_q  <= held_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (rx0_pclk),
    .rst_n (rstbtn_n),
    .inc   (drop_inc),
    .cnt   (drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_short_cnt (
    .clk   (rx0_pclk),
    .rst_n (rstbtn_n),
    .inc   (short_inc),
    .cnt   (short_cnt)
  );

  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_video_seg_packer.sv
// tb/tb_video_seg_packer.sv - randomized self-checking bench with a segment-level reference model
module tb_video_seg_packer;
  import video_seg_pkg::*;

  localparam int SEG = 640;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_en = 1'b0;
  logic [10:0] vcnt = '0;
  logic [11:0] idx = '0;
  logic [23:0] pix = '0;
  logic        pf = 1'b0;
  logic        full = 1'b0;
  logic [48:0] din;
  logic        wr;
  logic [15:0] drop_cnt, short_cnt;
  logic        ovf;

  logic        en2 = 1'b0;
  logic        pf2 = 1'b0;
  logic [48:0] din2;
  logic        wr2;
  logic [3:0]  drop2, short2;
  logic        ovf2;

  typedef struct {
    bit          en;
    logic [23:0] pix;
    logic [11:0] idx;
    logic [10:0] vcnt;
    bit          pf;
    bit          full;
  } stim_t;

  stim_t       stim_q[$];
  logic [48:0] got_q[$];
  int          got_cyc[$];
  logic [48:0] exp_q[$];
  int          exp_drop, exp_short;
  bit          exp_ovf;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          wr2_seen = 0;

  video_seg_packer #(.SEG_PIXELS(SEG), .CNT_W(16)) dut (
    .rx0_pclk(clk), .rstbtn_n(rst_n), .video_en(video_en), .video_vcnt(vcnt),
    .index(idx), .red(pix[23:16]), .green(pix[15:8]), .blue(pix[7:0]),
    .fifo_full(full), .fifo_prog_full(pf), .fifo_din(din), .fifo_wr_en(wr),
    .drop_cnt(drop_cnt), .short_cnt(short_cnt), .overflow(ovf)
  );

  video_seg_packer #(.SEG_PIXELS(4), .CNT_W(4)) dut_small (
    .rx0_pclk(clk), .rstbtn_n(rst_n), .video_en(en2), .video_vcnt(vcnt),
    .index(idx), .red(pix[23:16]), .green(pix[15:8]), .blue(pix[7:0]),
    .fifo_full(1'b0), .fifo_prog_full(pf2), .fifo_din(din2), .fifo_wr_en(wr2),
    .drop_cnt(drop2), .short_cnt(short2), .overflow(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      got_q.push_back(din);
      got_cyc.push_back(cyc);
    end
    if (wr2 === 1'b1) wr2_seen++;
  end

  function automatic logic [48:0] hdr(input logic [11:0] i, input logic [10:0] v);
    return {1'b1, 16'hA55A, 4'h0, i, v, 5'h0};
  endfunction

  task automatic drive(input bit en, input logic [23:0] p, input logic [11:0] i,
                       input logic [10:0] v, input bit f_pf, input bit f_full);
    stim_t s;
    @(negedge clk);
    video_en = en; pix = p; idx = i; vcnt = v; pf = f_pf; full = f_full;
    s.en = en; s.pix = p; s.idx = i; s.vcnt = v; s.pf = f_pf; s.full = f_full;
    stim_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 24'($urandom), 12'($urandom), 11'($urandom), 1'b0, 1'b0);
  endtask

  // Walks the recorded input history line by line, segment by segment.
  function automatic void build_expected();
    int  n, i, j, sl;
    bit  ok;
    exp_q.delete();
    exp_drop = 0; exp_short = 0; exp_ovf = 0;
    n = stim_q.size();
    i = 0;
    while (i < n) begin
      if (!stim_q[i].en) begin i++; continue; end
      j = i;
      while (j < n && stim_q[j].en) j++;
      for (int s = i; s < j; s += SEG) begin
        sl = (j - s < SEG) ? j - s : SEG;
        ok = 1;
        if (sl < SEG) exp_short++;
        if (stim_q[s].pf) begin exp_drop++; continue; end
        if (stim_q[s].full) begin exp_ovf = 1; continue; end
        exp_q.push_back(hdr(stim_q[s].idx, stim_q[s].vcnt));
        for (int k = 1; k < sl; k += 2) begin
          if (stim_q[s+k].full) begin exp_ovf = 1; ok = 0; break; end
          exp_q.push_back({1'b0, stim_q[s+k-1].pix, stim_q[s+k].pix});
        end
        if (ok && (sl % 2 == 1)) begin
          if (j < n && stim_q[j].full) exp_ovf = 1;
          else exp_q.push_back({1'b0, stim_q[s+sl-1].pix, 24'h0});
        end
      end
      i = j;
    end
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL reset.wr_en: got %b expected 0", wr); end
    tests++; if (din !== 49'h0) begin fails++; $display("FAIL reset.din: got %h expected 0", din); end
    tests++; if (drop_cnt !== 16'h0) begin fails++; $display("FAIL reset.drop_cnt: got %0d expected 0", drop_cnt); end
    tests++; if (short_cnt !== 16'h0) begin fails++; $display("FAIL reset.short_cnt: got %0d expected 0", short_cnt); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset.overflow: got %b expected 0", ovf); end
  endtask

  task automatic test_full_line();
    int base, bad;
    idle(2);
    for (int n = 0; n < 1280; n++) begin
      drive(1'b1, 24'(n), (n < 640) ? 12'd5 : 12'd6, 11'd3, 1'b0, 1'b0);
      if (n == 0) base = cyc;
    end
    idle(3);
    tests++; if (got_q.size() !== 642) begin fails++; $display("FAIL full_line.count: got %0d expected 642", got_q.size()); end
    tests++; if (got_q[0] !== {1'b1, 16'hA55A, 4'h0, 12'h005, 11'h003, 5'h0}) begin fails++; $display("FAIL full_line.header0: got %h expected %h", got_q[0], {1'b1, 16'hA55A, 4'h0, 12'h005, 11'h003, 5'h0}); end
    tests++; if (got_cyc[0] !== base + 1) begin fails++; $display("FAIL full_line.latency: got cycle %0d expected %0d", got_cyc[0], base + 1); end
    tests++; if (got_q[1] !== {1'b0, 24'h000000, 24'h000001}) begin fails++; $display("FAIL full_line.data0: got %h expected %h", got_q[1], {1'b0, 24'h0, 24'h1}); end
    tests++; if (got_q[321] !== hdr(12'd6, 11'd3)) begin fails++; $display("FAIL full_line.header1: got %h expected %h", got_q[321], hdr(12'd6, 11'd3)); end
    build_expected();
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    tests++; if (bad >= 0) begin fails++; $display("FAIL full_line.words: word %0d got %h expected %h", bad, got_q[bad], exp_q[bad]); end
    tests++; if (short_cnt !== 16'(exp_short) || drop_cnt !== 16'(exp_drop)) begin fails++; $display("FAIL full_line.counters: got drop %0d short %0d expected %0d %0d", drop_cnt, short_cnt, exp_drop, exp_short); end
  endtask

  task automatic test_prog_full();
    int s0, bad;
    s0 = got_q.size();
    for (int n = 0; n < 1280; n++) drive(1'b1, 24'($urandom), (n < 640) ? 12'd7 : 12'd8, 11'd4, n < 8, 1'b0);
    idle(3);
    tests++; if (got_q.size() - s0 !== 321) begin fails++; $display("FAIL prog_full.count: got %0d expected 321", got_q.size() - s0); end
    tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL prog_full.drop_cnt: got %0d expected 1", drop_cnt); end
    build_expected();
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    tests++; if (bad >= 0 || got_q.size() !== exp_q.size()) begin fails++; $display("FAIL prog_full.words: first bad %0d, got %0d words expected %0d", bad, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_short();
    int s0, bad;
    s0 = got_q.size();
    for (int n = 0; n < 101; n++) drive(1'b1, 24'(n), 12'd9, 11'd20, 1'b0, 1'b0);
    idle(3);
    tests++; if (got_q.size() - s0 !== 52) begin fails++; $display("FAIL short.count: got %0d expected 52", got_q.size() - s0); end
    tests++; if (got_q[got_q.size()-1] !== {1'b0, 24'd100, 24'h0}) begin fails++; $display("FAIL short.last: got %h expected %h", got_q[got_q.size()-1], {1'b0, 24'd100, 24'h0}); end
    tests++; if (short_cnt !== 16'd1) begin fails++; $display("FAIL short.short_cnt: got %0d expected 1", short_cnt); end
    tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL short.state: got %0d expected IDLE", dut.state_q); end
    build_expected();
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    tests++; if (bad >= 0 || got_q.size() !== exp_q.size()) begin fails++; $display("FAIL short.words: first bad %0d, got %0d words expected %0d", bad, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_overflow();
    int s0, bad;
    s0 = got_q.size();
    for (int n = 0; n < 1280; n++) drive(1'b1, 24'($urandom), (n < 640) ? 12'd11 : 12'd12, 11'd30, 1'b0, n == 21);
    idle(3);
    tests++; if (got_q.size() - s0 !== 332) begin fails++; $display("FAIL overflow.count: got %0d expected 332", got_q.size() - s0); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL overflow.flag: got %b expected 1", ovf); end
    tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL overflow.drop_cnt: got %0d expected 1", drop_cnt); end
    tests++; if (got_q[s0+11] !== hdr(12'd12, 11'd30)) begin fails++; $display("FAIL overflow.next_header: got %h expected %h", got_q[s0+11], hdr(12'd12, 11'd30)); end
    build_expected();
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    tests++; if (bad >= 0 || got_q.size() !== exp_q.size()) begin fails++; $display("FAIL overflow.words: first bad %0d, got %0d words expected %0d", bad, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int n = 0; n < 50; n++) drive(1'b1, 24'(n + 1000), 12'd13, 11'd40, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({wr, din, drop_cnt, short_cnt, ovf} !== '0) begin fails++; $display("FAIL reset_mid.async: got wr %b din %h drop %0d short %0d ovf %b expected all 0", wr, din, drop_cnt, short_cnt, ovf); end
    @(negedge clk) video_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim_q.delete(); got_q.delete(); got_cyc.delete();
    idle(2);
    for (int n = 0; n < 100; n++) drive(1'b1, 24'(n + 500), 12'd9, 11'd10, 1'b0, 1'b0);
    idle(3);
    tests++; if (got_q[0] !== hdr(12'd9, 11'd10)) begin fails++; $display("FAIL reset_mid.header: got %h expected %h", got_q[0], hdr(12'd9, 11'd10)); end
    tests++; if (got_q[1] !== {1'b0, 24'd500, 24'd501}) begin fails++; $display("FAIL reset_mid.data0: got %h expected %h", got_q[1], {1'b0, 24'd500, 24'd501}); end
    build_expected();
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    tests++; if (bad >= 0 || got_q.size() !== exp_q.size()) begin fails++; $display("FAIL reset_mid.words: first bad %0d, got %0d words expected %0d", bad, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int len, bad;
    for (int l = 0; l < 6; l++) begin
      idle($urandom_range(5, 1));
      len = $urandom_range(1400, 1);
      for (int n = 0; n < len; n++)
        drive(1'b1, 24'($urandom), 12'($urandom), 11'($urandom),
              $urandom_range(7, 0) == 0, $urandom_range(299, 0) == 0);
    end
    idle(3);
    build_expected();
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL random.count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
    tests++; if (bad >= 0) begin fails++; $display("FAIL random.words: word %0d got %h expected %h", bad, got_q[bad], exp_q[bad]); end
    tests++; if (drop_cnt !== 16'(exp_drop)) begin fails++; $display("FAIL random.drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
    tests++; if (short_cnt !== 16'(exp_short)) begin fails++; $display("FAIL random.short_cnt: got %0d expected %0d", short_cnt, exp_short); end
    tests++; if (ovf !== exp_ovf) begin fails++; $display("FAIL random.overflow: got %b expected %b", ovf, exp_ovf); end
  endtask

  task automatic test_drop_saturate();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      en2 = 1'b1; pf2 = 1'b1; pix = 24'($urandom);
    end
    @(negedge clk);
    tests++; if (drop2 !== 4'd10) begin fails++; $display("FAIL saturate.mid: got %0d expected 10", drop2); end
    for (int n = 0; n < 40; n++) begin
      pix = 24'($urandom);
      @(negedge clk);
    end
    tests++; if (drop2 !== 4'hF) begin fails++; $display("FAIL saturate.sticky: got %h expected f", drop2); end
    tests++; if (wr2_seen !== 0) begin fails++; $display("FAIL saturate.no_writes: got %0d writes expected 0", wr2_seen); end
    en2 = 1'b0; pf2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_prog_full();
    test_short();
    test_overflow();
    test_reset_mid();
    test_random();
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_seg_packer.md
Name: video_seg_packer

Overview:
- Sits directly downstream of the TMDS timing stage in the rx0_pclk domain.
- Consumes video_en, video_vcnt, index and the decoded 8-bit R/G/B pixel stream.
- Slices each active line into fixed-length segments and packs pixel pairs into 49-bit words behind one header word per segment.
- Writes the words into the Ethernet-side async FIFO write port, dropping whole segments when the FIFO cannot absorb them.

Parameters:
- SEG_PIXELS, 640, pixels per segment; must be even. Two segments per 1280-pixel line.
- CNT_W, 16, width of the drop and short-segment counters.

Ports:
- rx0_pclk  in  1  pixel clock, all logic rising-edge.
- rstbtn_n  in  1  asynchronous, active-low reset.
- video_en  in  1  active-pixel qualifier from the timing stage.
- video_vcnt  in  11  active line number.
- index  in  12  segment index from the timing stage.
- red  in  8  pixel red.
- green  in  8  pixel green.
- blue  in  8  pixel blue.
- fifo_full  in  1  FIFO full.
- fifo_prog_full  in  1  asserted when free space is below 1+SEG_PIXELS/2 words.
- fifo_din  out  49  bit48 = header flag, bits47:0 = payload.
- fifo_wr_en  out  1  write strobe.
- drop_cnt  out  CNT_W  segments dropped; saturating.
- short_cnt  out  CNT_W  segments ended early by video_en fall; saturating.
- overflow  out  1  sticky: fifo_full seen while writing.

Behaviour:
- Reset (async, rstbtn_n=0): fifo_din=0, fifo_wr_en=0, drop_cnt=0, short_cnt=0, overflow=0, state=IDLE, pixel counter=0, pair register=0.
- Pixel word = {red,green,blue} (24b).
- Data word = {1'b0, first pixel[23:0], second pixel[23:0]}.
- Header word = {1'b1, 16'hA55A, 4'h0, index[11:0], video_vcnt[10:0], 5'h0}. index and video_vcnt are sampled on the segment's first-pixel cycle.
- Latency: all FIFO outputs are registered. A write occurs exactly 1 cycle after the sampling cycle. At most one write per cycle.
- FSM states: IDLE, SEND, DROP.
- IDLE:
  - On video_en=1 with fifo_prog_full=0: write header, hold pixel 0 in the pair register, counter=1, go to SEND.
  - On video_en=1 with fifo_prog_full=1: drop_cnt+1, counter=1, go to DROP.
- SEND, each video_en=1 cycle:
  - Odd counter: write pair {held, current}.
  - Even counter: hold current pixel.
  - Counter increments every pixel.
  - When counter reaches SEG_PIXELS with video_en still 1, the current pixel becomes pixel 0 of the next segment. The header/drop decision for it is made in that same cycle, identical to IDLE. This gives a back-to-back segment with no gap: header at even slot 0, where no pair write is pending.
- DROP: count pixels with no writes. At SEG_PIXELS, apply the segment-start decision as above.
- video_en falls mid-segment (counter ≠ SEG_PIXELS):
  - SEND with a held odd pixel: write {held, 24'h0}.
  - short_cnt+1 (SEND or DROP).
  - Go to IDLE, counter=0.
- video_en falls exactly at counter==SEG_PIXELS: normal end; no short_cnt increment.
- fifo_full=1 on any cycle a write would be issued in SEND:
  - Suppress the write, set overflow=1 (cleared only by reset).
  - Go to DROP for the remainder of the segment. The segment is not counted in drop_cnt.
- Counters saturate at all-ones.
- Asynchronous reset mid-segment aborts immediately; no partial words are emitted after release.
- Counter width: $clog2(SEG_PIXELS+1).

Decomposition:
- Shared package video_seg_pkg holds:
  - HDR_MAGIC = 16'hA55A
  - FIFO_W = 49
  - HDR_FLAG_BIT = 48
  - state enum {IDLE, SEND, DROP}
  - header field offsets, reused by the Ethernet-side depacketizer
- One sub-module, sat_counter (parameter W; inc → saturating count), instantiated twice for drop_cnt and short_cnt.

Test Plan:
- Reset, then 1280-pixel line, fifo_prog_full=0, index=5, vcnt=3, pixel n = n:
  - Writes: header {1,A55A,0,005,003,0}; 320 data words; second header with index sampled at pixel 640; 320 data words.
  - 642 writes total; first data word = {0, 000000, 000001}.
- fifo_prog_full=1 at pixel 0, low by pixel 640:
  - First segment produces no writes; drop_cnt=1.
  - Second segment is complete, 321 writes.
- video_en falls after 101 pixels:
  - Header + 50 pairs + final {pixel100, 000000}: 52 writes.
  - short_cnt=1; FSM in IDLE.
- fifo_full pulsed at data word 10:
  - Word 10 is not written and overflow=1.
  - No further writes until the next segment, which starts normally with a header.
  - drop_cnt unchanged.
- rstbtn_n asserted mid-SEND:
  - Outputs are zero immediately (asynchronously).
  - After release, the next video_en produces a fresh header with counter restarting at 0.
- 65536 dropped segments: drop_cnt sticks at 16'hFFFF.
